// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD adder/subtractor.
// Contents: FSM state codes, BCD digit width and constants, and the
// nines() helper that returns the nines complement of one BCD digit.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_CORR = 4'd6;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic [DIGIT_W-1:0] nines(input logic [DIGIT_W-1:0] d);
        return BCD_MAX - d;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder with decimal correction (purely combinational).
// Ports:
//   x, y  : BCD digit inputs
//   cin   : carry in
//   s     : corrected BCD digit out
//   cout  : decimal carry out (binary sum > 9)
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               cin,
    output logic [DIGIT_W-1:0] s,
    output logic               cout
);

    logic [DIGIT_W:0] bin;

    always_comb begin
        bin  = {1'b0, x} + {1'b0, y} + {{DIGIT_W{1'b0}}, cin};
        cout = (bin > {1'b0, BCD_MAX});
        // Adding 6 modulo 16 skips the six unused codes 10..15.
        s    = cout ? (bin[DIGIT_W-1:0] + BCD_CORR) : bin[DIGIT_W-1:0];
    end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial multi-digit BCD adder/subtractor, LSD first, one digit per
// clock through a single shared bcd_digit_add. Subtraction adds the ten's
// complement of b; a negative difference is turned back into a magnitude
// by a second serial pass (FIX).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start, sub : request and operation (0 add, 1 subtract), sampled in IDLE
//   a, b       : packed BCD operands, digit 0 in bits [3:0]
//   busy       : high outside IDLE
//   done       : one-cycle pulse, outputs valid
//   result     : packed BCD sum or difference magnitude
//   cout       : decimal carry out of the MSD (add only)
//   neg        : difference was negative (sub only)
//   invalid    : operand digit > 9 seen at start
// Optional: define BCD_INVALID_CHECK_EN to build the invalid-digit check;
// otherwise invalid is tied to 0.
module bcd_addsub_serial
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int CNT_W  = $clog2(DIGITS) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    sub,
    input  logic [DIGIT_W*DIGITS-1:0] a,
    input  logic [DIGIT_W*DIGITS-1:0] b,
    output logic                    busy,
    output logic                    done,
    output logic [DIGIT_W*DIGITS-1:0] result,
    output logic                    cout,
    output logic                    neg,
    output logic                    invalid
);

    localparam int W = DIGIT_W * DIGITS;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

    logic [1:0]       state_q, state_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, res_q, res_d, b_nines;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d, sub_q, sub_d;
    logic             cout_q, cout_d, neg_q, neg_d;

    logic [DIGIT_W-1:0] add_x, add_y, add_s;
    logic               add_co;
    logic [W+DIGIT_W-1:0] res_shift;

    // FIX reuses the adder as nines(digit) + 0 + carry.
    assign add_x = (state_q == ST_FIX) ? nines(res_q[DIGIT_W-1:0]) : a_q[DIGIT_W-1:0];
    assign add_y = (state_q == ST_FIX) ? '0 : b_q[DIGIT_W-1:0];

    bcd_digit_add u_add (
        .x    (add_x),
        .y    (add_y),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_co)
    );

    // New digit enters at the MSD end; after DIGITS shifts digit 0 sits at [3:0].
    assign res_shift = {add_s, res_q};

    always_comb begin
        for (int i = 0; i < DIGITS; i++)
            b_nines[i*DIGIT_W +: DIGIT_W] = nines(b[i*DIGIT_W +: DIGIT_W]);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        cout_d  = cout_q;
        neg_d   = neg_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? b_nines : b;
                    sub_d   = sub;
                    carry_d = sub;      // the +1 of the ten's complement
                    cnt_d   = '0;
                    res_d   = '0;
                    cout_d  = 1'b0;
                    neg_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> DIGIT_W;
                b_d     = b_q >> DIGIT_W;
                res_d   = res_shift[W+DIGIT_W-1:DIGIT_W];
                carry_d = add_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    if (!sub_q) begin
                        cout_d  = add_co;
                        state_d = ST_DONE;
                    end else if (add_co) begin
                        state_d = ST_DONE;
                    end else begin
                        // No carry out of a ten's-complement add: a < b.
                        carry_d = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                res_d   = res_shift[W+DIGIT_W-1:DIGIT_W];
                carry_d = add_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    neg_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;  // ST_DONE
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            cout_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            cout_q  <= cout_d;
            neg_q   <= neg_d;
        end
    end

`ifdef BCD_INVALID_CHECK_EN
    logic inv_q, inv_d;

    always_comb begin
        inv_d = inv_q;
        if (state_q == ST_IDLE && start) begin
            inv_d = 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                if (a[i*DIGIT_W +: DIGIT_W] > BCD_MAX || b[i*DIGIT_W +: DIGIT_W] > BCD_MAX)
                    inv_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) inv_q <= 1'b0;
        else     inv_q <= inv_d;
    end

    assign invalid = inv_q;
`else
    assign invalid = 1'b0;
`endif

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = res_q;
    assign cout   = cout_q;
    assign neg    = neg_q;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Directed self-checking bench for bcd_addsub_serial with DIGITS=4.
// Latency is counted in cycles from the cycle in which start is accepted
// (cycle 0) to the cycle in which done is high.
module tb_bcd_addsub_serial;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout, neg, invalid;
    logic [W-1:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_addsub_serial #(.DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .sub     (sub),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .cout    (cout),
        .neg     (neg),
        .invalid (invalid)
    );

    always #5 clk = ~clk;

    // Launch one operation and wait (bounded) for its done pulse.
    // lat = -1 if done never arrived.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                         output logic [W-1:0] r, output logic co, output logic ng,
                         output logic inv, output int lat);
        lat = -1;
        r = 'x; co = 1'bx; ng = 1'bx; inv = 1'bx;
        @(negedge clk);
        a = av; b = bv; sub = sv; start = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = cyc; r = result; co = cout; ng = neg; inv = invalid;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; a = 16'h1234; b = 16'h5678;
        repeat (3) @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (result !== 16'h0)   begin n_fail++; $display("FAIL reset_result got %h want 0000", result); end
        n_checks++; if (cout !== 1'b0)      begin n_fail++; $display("FAIL reset_cout got %b want 0", cout); end
        n_checks++; if (neg !== 1'b0)       begin n_fail++; $display("FAIL reset_neg got %b want 0", neg); end
        n_checks++; if (invalid !== 1'b0)   begin n_fail++; $display("FAIL reset_invalid got %b want 0", invalid); end
    endtask

    task automatic test_add;
        logic [W-1:0] r; logic co, ng, inv; int lat;
        do_op(16'h1234, 16'h5678, 1'b0, r, co, ng, inv, lat);
        n_checks++; if (lat !== 5)        begin n_fail++; $display("FAIL add1_latency got %0d want 5", lat); end
        n_checks++; if (r !== 16'h6912)   begin n_fail++; $display("FAIL add1_result got %h want 6912", r); end
        n_checks++; if (co !== 1'b0)      begin n_fail++; $display("FAIL add1_cout got %b want 0", co); end
        n_checks++; if (ng !== 1'b0)      begin n_fail++; $display("FAIL add1_neg got %b want 0", ng); end
        do_op(16'h9999, 16'h0001, 1'b0, r, co, ng, inv, lat);
        n_checks++; if (lat !== 5)        begin n_fail++; $display("FAIL add_ovf_latency got %0d want 5", lat); end
        n_checks++; if (r !== 16'h0000)   begin n_fail++; $display("FAIL add_ovf_result got %h want 0000", r); end
        n_checks++; if (co !== 1'b1)      begin n_fail++; $display("FAIL add_ovf_cout got %b want 1", co); end
        do_op(16'h0000, 16'h0000, 1'b0, r, co, ng, inv, lat);
        n_checks++; if (r !== 16'h0000)   begin n_fail++; $display("FAIL add_zero_result got %h want 0000", r); end
        n_checks++; if (co !== 1'b0)      begin n_fail++; $display("FAIL add_zero_cout got %b want 0", co); end
        // Held after done until the next start.
        repeat (3) @(negedge clk);
        n_checks++; if (result !== 16'h0000 || busy !== 1'b0)
            begin n_fail++; $display("FAIL add_hold got result %h busy %b want 0000 0", result, busy); end
    endtask

    task automatic test_sub;
        logic [W-1:0] r; logic co, ng, inv; int lat;
        do_op(16'h5000, 16'h1234, 1'b1, r, co, ng, inv, lat);
        n_checks++; if (lat !== 5)        begin n_fail++; $display("FAIL sub_pos_latency got %0d want 5", lat); end
        n_checks++; if (r !== 16'h3766)   begin n_fail++; $display("FAIL sub_pos_result got %h want 3766", r); end
        n_checks++; if (ng !== 1'b0)      begin n_fail++; $display("FAIL sub_pos_neg got %b want 0", ng); end
        n_checks++; if (co !== 1'b0)      begin n_fail++; $display("FAIL sub_pos_cout got %b want 0", co); end
        do_op(16'h1234, 16'h5000, 1'b1, r, co, ng, inv, lat);
        n_checks++; if (lat !== 9)        begin n_fail++; $display("FAIL sub_neg_latency got %0d want 9", lat); end
        n_checks++; if (r !== 16'h3766)   begin n_fail++; $display("FAIL sub_neg_result got %h want 3766", r); end
        n_checks++; if (ng !== 1'b1)      begin n_fail++; $display("FAIL sub_neg_neg got %b want 1", ng); end
        n_checks++; if (co !== 1'b0)      begin n_fail++; $display("FAIL sub_neg_cout got %b want 0", co); end
        do_op(16'h4321, 16'h4321, 1'b1, r, co, ng, inv, lat);
        n_checks++; if (lat !== 5)        begin n_fail++; $display("FAIL sub_zero_latency got %0d want 5", lat); end
        n_checks++; if (r !== 16'h0000)   begin n_fail++; $display("FAIL sub_zero_result got %h want 0000", r); end
        n_checks++; if (ng !== 1'b0)      begin n_fail++; $display("FAIL sub_zero_neg got %b want 0", ng); end
        // neg from the previous op must be cleared by this start
        do_op(16'h0100, 16'h0099, 1'b1, r, co, ng, inv, lat);
        n_checks++; if (r !== 16'h0001 || ng !== 1'b0)
            begin n_fail++; $display("FAIL sub_borrow got %h neg %b want 0001 0", r, ng); end
    endtask

    task automatic test_ignore_start;
        int n_done = 0; int lat = -1; logic [W-1:0] r = 'x;
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; sub = 1'b0; start = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 2) begin
                a = 16'h1111; b = 16'h1111; sub = 1'b1; start = 1'b1;
            end
            if (done) begin
                n_done++;
                if (lat < 0) begin lat = cyc; r = result; end
            end
        end
        n_checks++; if (n_done !== 1)     begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", n_done); end
        n_checks++; if (lat !== 5)        begin n_fail++; $display("FAIL ignore_latency got %0d want 5", lat); end
        n_checks++; if (r !== 16'h6912)   begin n_fail++; $display("FAIL ignore_result got %h want 6912", r); end
    endtask

    task automatic test_reset_abort;
        int n_done = 0;
        logic [W-1:0] r; logic co, ng, inv; int lat;
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; sub = 1'b0; start = 1'b1;
        @(negedge clk);           // RUN cycle 1
        start = 1'b0;
        @(negedge clk);           // RUN cycle 2
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        n_checks++; if (result !== 16'h0 || cout !== 1'b0 || neg !== 1'b0 || done !== 1'b0)
            begin n_fail++; $display("FAIL abort_outputs got result %h cout %b neg %b done %b want 0", result, cout, neg, done); end
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        n_checks++; if (n_done !== 0)     begin n_fail++; $display("FAIL abort_no_done got %0d want 0", n_done); end
        do_op(16'h5000, 16'h1234, 1'b1, r, co, ng, inv, lat);
        n_checks++; if (lat !== 5 || r !== 16'h3766 || ng !== 1'b0)
            begin n_fail++; $display("FAIL abort_restart got lat %0d result %h neg %b want 5 3766 0", lat, r, ng); end
    endtask

    task automatic test_invalid;
        logic [W-1:0] r; logic co, ng, inv; int lat;
        logic exp_inv;
`ifdef BCD_INVALID_CHECK_EN
        exp_inv = 1'b1;
`else
        exp_inv = 1'b0;
`endif
        do_op(16'h12A4, 16'h0001, 1'b0, r, co, ng, inv, lat);
        n_checks++; if (lat !== 5 || inv !== exp_inv)
            begin n_fail++; $display("FAIL invalid_flag got lat %0d inv %b want 5 %b", lat, inv, exp_inv); end
        do_op(16'h1234, 16'h0001, 1'b0, r, co, ng, inv, lat);
        n_checks++; if (inv !== 1'b0 || r !== 16'h1235)
            begin n_fail++; $display("FAIL invalid_clear got inv %b result %h want 0 1235", inv, r); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_ignore_start();
        test_reset_abort();
        test_invalid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_addsub_serial.md
Name: bcd_addsub_serial

Overview:
Parametrised, digit-serial, multi-digit BCD adder/subtractor. It processes one BCD digit per clock, least-significant digit first, using a single one-digit BCD adder with decimal correction. Subtraction produces a signed-magnitude result; a negative difference is converted back to a positive magnitude by a second serial pass. The block is the multi-digit arithmetic engine behind the BCD display/calculator datapath and talks to its controller through a start/busy/done handshake.

Parameters:
DIGITS, 4, number of BCD digits per operand and result (legal range 1..16)
CNT_W, $clog2(DIGITS)+1, width of the digit counter (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
sub  input  1  0 = a+b, 1 = a-b; sampled with start
a  input  4*DIGITS  operand A, packed BCD, digit 0 = bits [3:0]
b  input  4*DIGITS  operand B, packed BCD
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse, result valid
result  output  4*DIGITS  packed BCD sum or magnitude of the difference
cout  output  1  decimal carry out of the MSD (add only)
neg  output  1  difference negative (sub only)
invalid  output  1  operand digit >9 detected (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst=1 at a clk edge: state=IDLE; result, cout, neg, invalid, done and busy all 0; the operand shift registers and the digit counter are cleared.
- States: IDLE, RUN, FIX, DONE.
- IDLE: when start=1, latch a, b and sub. If sub=1, replace b with its nines complement (each digit d becomes 9-d). Set the carry register to sub (this supplies the +1 of the ten's complement). Clear the counter. Go to RUN.
- RUN: each cycle, add digit[cnt] of A, digit[cnt] of B and the carry. Apply decimal correction: if the binary sum is >9, add 6 and set carry=1. Shift the result digit into result. After DIGITS cycles:
  - Add: cout = final carry, neg = 0, go to DONE.
  - Sub with final carry 1: neg = 0, cout = 0, go to DONE.
  - Sub with final carry 0 (negative difference): go to FIX.
- FIX: compute the ten's complement of result serially, one digit per cycle. Each digit becomes nines complement + carry, with carry initialised to 1, using the same digit adder. This takes DIGITS cycles. Then neg = 1, cout = 0, go to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE.
- Latency from the accepting edge to done high:
  - add, or non-negative difference: DIGITS+1 cycles
  - negative difference: 2*DIGITS+1 cycles
- Outputs result, cout, neg and invalid are held from DONE until the next accepted start, then cleared on that start.
- start while busy=1 is ignored; no queueing.
- start in the DONE cycle is ignored; the earliest restart is the following IDLE cycle.
- A zero difference (a==b, sub=1) gives result 0 and neg=0.
- Add overflow (for example 9999+0001 with DIGITS=4) gives result 0000 and cout=1.
- rst mid-operation aborts immediately: no done pulse, all outputs 0 on the next cycle.

Optional Feature:
BCD_INVALID_CHECK_EN
- Defined: on the accepting start, flag any digit of a or b greater than 9. invalid is registered with the operands and held through DONE. Arithmetic proceeds regardless, and the result is unspecified when invalid=1.
- Undefined: invalid is tied to 0 and no comparators are built.

Decomposition:
- Package bcd_pkg:
  - state enumeration: IDLE, RUN, FIX, DONE
  - DIGIT_W = 4
  - BCD_MAX = 4'd9
  - BCD_CORR = 4'd6
  - function nines(d) returning 9-d
- Sub-module bcd_digit_add: purely combinational one-digit add with correction. Inputs are two 4-bit digits and a carry-in; outputs are a 4-bit digit and a carry-out. Instantiate it once, shared by the RUN and FIX passes.

Test Plan:
- DIGITS=4, add 1234 + 5678 -> result 6912, cout 0, neg 0; done exactly 5 cycles after the accepting edge.
- Add 9999 + 0001 -> result 0000, cout 1; add 0000 + 0000 -> result 0000, cout 0.
- Sub 5000 - 1234 -> result 3766, neg 0, done at 5 cycles; sub 1234 - 5000 -> result 3766, neg 1, done at 9 cycles; sub 4321 - 4321 -> result 0000, neg 0.
- Pulse start again 2 cycles after acceptance with different operands -> ignored; first result is returned unchanged and only one done pulse occurs.
- Assert rst at RUN cycle 2 -> busy 0 and all outputs 0 next cycle, no done; a fresh start then completes normally.
- With BCD_INVALID_CHECK_EN defined, a=12A4 -> invalid 1 at done. Without the macro, invalid stays 0.
